// File: rtl/dm_be_pkg.sv
// Shared definitions for the byte-enable data memory: op encodings,
// clear-FSM states, default geometry and the alignment/legality check.
package dm_be_pkg;

    localparam int unsigned DM_ADDR_WIDTH = 10;
    localparam int unsigned DM_DATA_W     = 32;

    localparam logic [2:0] DM_OP_W  = 3'b000;
    localparam logic [2:0] DM_OP_H  = 3'b001;
    localparam logic [2:0] DM_OP_HU = 3'b010;
    localparam logic [2:0] DM_OP_B  = 3'b011;
    localparam logic [2:0] DM_OP_BU = 3'b100;

    typedef enum logic {
        DM_CLEAR = 1'b0,
        DM_READY = 1'b1
    } dm_state_e;

    // Misaligned halfword/word or an unassigned op encoding.
    function automatic logic dm_addr_err(input logic [2:0] op, input logic [1:0] lane);
        logic err;
        case (op)
            DM_OP_W:           err = (lane != 2'b00);
            DM_OP_H, DM_OP_HU: err = lane[0];
            DM_OP_B, DM_OP_BU: err = 1'b0;
            default:           err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/dm_be_ext.sv
// Load extractor: selects the addressed byte/halfword of a word and
// sign- or zero-extends it according to op.
// Ports: i_word (stored word), i_lane (addr[1:0]), i_op (access type),
//        o_dout_c (extended load value, combinational).
module dm_be_ext
    import dm_be_pkg::*;
(
    input  logic [DM_DATA_W-1:0] i_word,
    input  logic [1:0]           i_lane,
    input  logic [2:0]           i_op,
    output logic [DM_DATA_W-1:0] o_dout_c
);

    logic [15:0] w_half;
    logic [7:0]  w_byte;

    // Lane selection then extension.
    always_comb begin
        w_half   = i_lane[1] ? i_word[31:16] : i_word[15:0];
        case (i_lane)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
        o_dout_c = '0;
        case (i_op)
            DM_OP_W:  o_dout_c = i_word;
            DM_OP_H:  o_dout_c = {{16{w_half[15]}}, w_half};
            DM_OP_HU: o_dout_c = {16'h0000, w_half};
            DM_OP_B:  o_dout_c = {{24{w_byte[7]}}, w_byte};
            DM_OP_BU: o_dout_c = {24'h000000, w_byte};
            default:  o_dout_c = '0;
        endcase
    end

endmodule

// File: rtl/dm_be.sv
// Byte-enable data memory for the MEM stage: W/H/B stores with lane
// enables, signed/unsigned sub-word loads (zero latency), misalignment and
// illegal-op detection, and a sequential clear engine run after every reset.
// Ports: clk, rst (sync, active-high), addr (byte address, wraps), din
//        (right-justified store data), we, op, dout (load result), busy
//        (clear in progress), addr_err (misaligned or illegal op).
module dm_be
    import dm_be_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DM_ADDR_WIDTH,
    parameter logic [31:0] INIT_VALUE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    input  logic        we,
    input  logic [2:0]  op,
    output logic [31:0] dout,
    output logic        busy,
    output logic        addr_err
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [31:0]           r_ram [DEPTH];
    dm_state_e             r_state;
    dm_state_e             w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_clr_idx;
    logic [ADDR_WIDTH-1:0] w_clr_idx_nxt;
    logic                  w_clr_we;

    logic [ADDR_WIDTH-1:0] w_widx;
    logic [1:0]            w_lane;
    logic [3:0]            w_be;
    logic [31:0]           w_wdata;
    logic                  w_user_we;
    logic [31:0]           w_ext;
    logic                  w_unused_addr;

    assign w_widx        = addr[ADDR_WIDTH+1:2];
    assign w_lane        = addr[1:0];
    // Upper address bits are deliberately dropped so accesses wrap.
    assign w_unused_addr = &{1'b0, addr[31:ADDR_WIDTH+2]};

    assign addr_err  = dm_addr_err(op, w_lane);
    assign busy      = (r_state == DM_CLEAR);
    assign w_user_we = we && !addr_err && (r_state == DM_READY);

    // Clear FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= DM_CLEAR;
            r_clr_idx <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_idx <= w_clr_idx_nxt;
        end
    end

    // Clear FSM next state: walk every word once, then go READY.
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_idx_nxt = r_clr_idx;
        w_clr_we      = 1'b0;
        case (r_state)
            DM_CLEAR: begin
                w_clr_we      = 1'b1;
                w_clr_idx_nxt = r_clr_idx + ADDR_WIDTH'(1);
                if (r_clr_idx == '1) begin
                    w_state_nxt = DM_READY;
                end
            end
            default: begin
                w_state_nxt = DM_READY;
            end
        endcase
    end

    // Lane mask and lane-replicated store data.
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = din;
        case (op)
            DM_OP_W: begin
                w_be = 4'b1111;
            end
            DM_OP_H, DM_OP_HU: begin
                w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
                w_wdata = {din[15:0], din[15:0]};
            end
            DM_OP_B, DM_OP_BU: begin
                w_be    = 4'b0001 << w_lane;
                w_wdata = {4{din[7:0]}};
            end
            default: begin
                w_be = 4'b0000;
            end
        endcase
    end

    // Storage: reset edges write nothing; the clear engine owns the port while busy.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_clr_we) begin
                r_ram[r_clr_idx] <= INIT_VALUE;
            end else if (w_user_we) begin
                for (int l = 0; l < 4; l++) begin
                    if (w_be[l]) begin
                        r_ram[w_widx][8*l +: 8] <= w_wdata[8*l +: 8];
                    end
                end
            end
        end
    end

    dm_be_ext u_ext (
        .i_word   (r_ram[w_widx]),
        .i_lane   (w_lane),
        .i_op     (op),
        .o_dout_c (w_ext)
    );

    assign dout = (busy || addr_err) ? 32'h0000_0000 : w_ext;

endmodule

// File: tb/tb_dm_be.sv
module tb_dm_be;

    localparam logic [2:0] OP_W  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_HU = 3'b010;
    localparam logic [2:0] OP_B  = 3'b011;
    localparam logic [2:0] OP_BU = 3'b100;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] din;
    logic        we;
    logic [2:0]  op;
    logic [31:0] dout;
    logic        busy;
    logic        addr_err;

    int errors;
    int checks;
    logic [31:0] sb_q[$];

    dm_be #(.ADDR_WIDTH(4), .INIT_VALUE(32'h0000_0000)) dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .din      (din),
        .we       (we),
        .op       (op),
        .dout     (dout),
        .busy     (busy),
        .addr_err (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_store(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d);
        op = o; addr = a; din = d; we = 1'b1;
        tick();
        we = 1'b0;
    endtask

    // Drive a load and record what it must return.
    task automatic issue_load(input logic [2:0] o, input logic [31:0] a, input logic [31:0] e);
        we = 1'b0; op = o; addr = a;
        sb_q.push_back(e);
        #1;
    endtask

    // Count edges until busy falls, bounded.
    task automatic wait_clear(output int cyc);
        cyc = 0;
        while (busy === 1'b1 && cyc < 200) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        int cyc;
        logic [31:0] e;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL reset_busy: got %b want 1", busy);
        end
        checks++;
        if (dout !== 32'h0) begin
            errors++; $display("FAIL reset_dout: got %h want 00000000", dout);
        end
        tick();
        tick();
        // Store while busy must not take effect.
        do_store(OP_W, 32'h0000_003C, 32'h1234_5678);
        wait_clear(cyc);
        cyc += 3;
        checks++;
        if (cyc !== 16) begin
            errors++; $display("FAIL reset_clear_len: got %0d cycles want 16", cyc);
        end
        for (int i = 0; i < 16; i++) begin
            issue_load(OP_W, 32'(i * 4), 32'h0);
            e = sb_q.pop_front();
            checks++;
            if (dout !== e) begin
                errors++; $display("FAIL reset_word%0d: got %h want %h", i, dout, e);
            end
            tick();
        end
    endtask

    task automatic test_subword_store();
        logic [31:0] e;
        do_store(OP_W, 32'h8, 32'h1122_3344);
        do_store(OP_B, 32'h9, 32'h0000_00AA);
        issue_load(OP_W, 32'h8, 32'h1122_AA44);
        e = sb_q.pop_front();
        checks++;
        if (dout !== e) begin
            errors++; $display("FAIL sb_merge: got %h want %h", dout, e);
        end
        tick();
        do_store(OP_H, 32'hA, 32'h0000_BEEF);
        issue_load(OP_W, 32'h8, 32'hBEEF_AA44);
        e = sb_q.pop_front();
        checks++;
        if (dout !== e) begin
            errors++; $display("FAIL sh_merge: got %h want %h", dout, e);
        end
        tick();
    endtask

    task automatic test_ext_load();
        logic [2:0]  ops  [6];
        logic [31:0] adrs [6];
        logic [31:0] exps [6];
        logic [31:0] e;
        ops  = '{OP_W, OP_B, OP_B, OP_BU, OP_H, OP_HU};
        adrs = '{32'h4, 32'h4, 32'h6, 32'h6, 32'h6, 32'h6};
        exps = '{32'h80FF_7F01, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_00FF,
                 32'hFFFF_80FF, 32'h0000_80FF};
        do_store(OP_W, 32'h4, 32'h80FF_7F01);
        for (int i = 0; i < 6; i++) begin
            issue_load(ops[i], adrs[i], exps[i]);
            e = sb_q.pop_front();
            checks++;
            if (dout !== e) begin
                errors++; $display("FAIL ext_load%0d op=%0d: got %h want %h", i, ops[i], dout, e);
            end
            tick();
        end
    endtask

    task automatic test_misalign();
        logic [2:0]  ops  [5];
        logic [31:0] adrs [5];
        logic        errs [5];
        logic [31:0] exps [5];
        logic [31:0] e;
        ops  = '{OP_W, OP_H, 3'b111, OP_BU, OP_HU};
        adrs = '{32'h8, 32'h9, 32'h8, 32'h9, 32'hA};
        errs = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        exps = '{32'h1122_3344, 32'h0, 32'h0, 32'h0000_0033, 32'h0000_1122};
        do_store(OP_W, 32'h8, 32'h1122_3344);
        op = OP_W; addr = 32'hA; din = 32'hDEAD_BEEF; we = 1'b1;
        #1;
        checks++;
        if (addr_err !== 1'b1) begin
            errors++; $display("FAIL sw_misalign_err: got %b want 1", addr_err);
        end
        tick();
        we = 1'b0;
        for (int i = 0; i < 5; i++) begin
            issue_load(ops[i], adrs[i], exps[i]);
            e = sb_q.pop_front();
            checks++;
            if (addr_err !== errs[i] || dout !== e) begin
                errors++;
                $display("FAIL misalign%0d: got err=%b dout=%h want err=%b dout=%h",
                         i, addr_err, dout, errs[i], e);
            end
            tick();
        end
    endtask

    task automatic test_reset_restart();
        int cyc;
        logic [31:0] e;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL midclear_busy: got %b want 1", busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_clear(cyc);
        checks++;
        if (cyc !== 16) begin
            errors++; $display("FAIL midclear_len: got %0d cycles want 16", cyc);
        end
        // Reset from READY with a store on the same edge.
        do_store(OP_W, 32'h18, 32'h0000_ABCD);
        rst = 1'b1; we = 1'b1; op = OP_W; addr = 32'h14; din = 32'h5;
        tick();
        rst = 1'b0; we = 1'b0;
        wait_clear(cyc);
        checks++;
        if (cyc !== 16) begin
            errors++; $display("FAIL ready_reset_len: got %0d cycles want 16", cyc);
        end
        issue_load(OP_W, 32'h14, 32'h0);
        e = sb_q.pop_front();
        checks++;
        if (dout !== e) begin
            errors++; $display("FAIL rst_prio_word: got %h want %h", dout, e);
        end
        tick();
        issue_load(OP_W, 32'h18, 32'h0);
        e = sb_q.pop_front();
        checks++;
        if (dout !== e) begin
            errors++; $display("FAIL reclear_word: got %h want %h", dout, e);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] e;
        do_store(OP_W, 32'h40, 32'hCAFE_F00D);
        issue_load(OP_W, 32'h0, 32'hCAFE_F00D);
        e = sb_q.pop_front();
        checks++;
        if (dout !== e) begin
            errors++; $display("FAIL wrap: got %h want %h", dout, e);
        end
        // Read during write sees the old word until the edge.
        sb_q.push_back(32'hCAFE_F00D);
        op = OP_W; addr = 32'h0; din = 32'h0000_0012; we = 1'b1;
        #1;
        e = sb_q.pop_front();
        checks++;
        if (dout !== e) begin
            errors++; $display("FAIL rdw_old: got %h want %h", dout, e);
        end
        tick();
        we = 1'b0;
        issue_load(OP_W, 32'h0, 32'h0000_0012);
        e = sb_q.pop_front();
        checks++;
        if (dout !== e) begin
            errors++; $display("FAIL rdw_new: got %h want %h", dout, e);
        end
        tick();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b0; we = 1'b0; op = OP_W; addr = 32'h0; din = 32'h0;
        #2;
        test_reset();
        test_subword_store();
        test_ext_load();
        test_misalign();
        test_reset_restart();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
